// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle core: opcode/funct values, FSM states, ALU ops.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU: add/sub/and/or/signed slt, plus a zero flag on the result.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = 32'h0;
    case (alu_op_t'(op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'h0, $signed(a) < $signed(b)};
      default: y = 32'h0;
    endcase
  end

  assign zero = (y == 32'h0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer over a small register file.
// 3-5 cycles per instruction plus one per ready=0 wait cycle; requests are held until accepted.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int          NREGS    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic        i_ready,
  input  logic [31:0] i_datain,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [31:0] d_dataout,
  input  logic        d_ready,
  input  logic [31:0] d_datain,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t      state;
  logic [31:0] ir, reg_a, reg_b, reg_c, reg_c1;
  logic [31:0] regs [NREGS];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] simm, pc_plus4, br_target, j_target;
  logic [31:0] rs_val, rt_val, alu_b, alu_y;
  logic        alu_zero, legal, dst_ok;
  alu_op_t     alu_op;
  logic        unused_bits;

  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign unused_bits = ^ir[10:6];
  assign simm        = {{16{ir[15]}}, ir[15:0]};
  assign pc_plus4    = pc + 32'd4;
  assign br_target   = pc_plus4 + {simm[29:0], 2'b00};
  assign j_target    = {pc_plus4[31:28], ir[25:0], 2'b00};

  assign i_addr    = pc;
  assign d_addr    = reg_c;
  assign d_dataout = reg_b;

  // Register 0 and any field beyond the implemented file read as zero.
  always_comb begin
    rs_val = 32'h0;
    rt_val = 32'h0;
    if (rs != 5'd0 && int'(rs) < NREGS) rs_val = regs[rs[IW-1:0]];
    if (rt != 5'd0 && int'(rt) < NREGS) rt_val = regs[rt[IW-1:0]];
  end

  assign dst    = (opcode == OP_RTYPE) ? rd : rt;
  assign dst_ok = (dst != 5'd0) && (int'(dst) < NREGS);

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin legal = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin legal = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin legal = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin legal = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin legal = 1'b1; alu_op = ALU_SLT; end
          default: legal = 1'b0;
        endcase
      end
      OP_BEQ:                    begin legal = 1'b1; alu_op = ALU_SUB; end
      OP_LW, OP_SW, OP_ADDI, OP_J: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
  end

  assign alu_b = (opcode == OP_RTYPE || opcode == OP_BEQ) ? reg_b : simm;

  cpu_alu u_alu (
    .op   (alu_op),
    .a    (reg_a),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= 32'h0;
      reg_a   <= 32'h0;
      reg_b   <= 32'h0;
      reg_c   <= 32'h0;
      reg_c1  <= 32'h0;
      i_req   <= 1'b0;
      d_req   <= 1'b0;
      d_we    <= 1'b0;
      retire  <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            i_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_ready) begin
            ir    <= i_datain;
            i_req <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          reg_a <= rs_val;
          reg_b <= rt_val;
          if (!legal) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          reg_c <= alu_y;
          case (opcode)
            OP_LW, OP_SW: begin
              state <= S_MEM;
              d_req <= 1'b1;
              d_we  <= (opcode == OP_SW);
            end
            OP_BEQ, OP_J: begin
              if (opcode == OP_J)  pc <= j_target;
              else if (alu_zero)   pc <= br_target;
              else                 pc <= pc_plus4;
              retire <= 1'b1;
              i_req  <= 1'b1;
              state  <= S_FETCH;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (d_ready) begin
            d_req <= 1'b0;
            d_we  <= 1'b0;
            if (opcode == OP_SW) begin
              retire <= 1'b1;
              pc     <= pc_plus4;
              i_req  <= 1'b1;
              state  <= S_FETCH;
            end else begin
              reg_c1 <= d_datain;
              state  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (dst_ok) regs[dst[IW-1:0]] <= (opcode == OP_LW) ? reg_c1 : reg_c;
          retire <= 1'b1;
          pc     <= pc_plus4;
          i_req  <= 1'b1;
          state  <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: instruction-level reference model, randomized program and wait states,
// plus directed cases for arithmetic results, branch/jump targets, halting and reset.
module tb_multicycle_cpu;

  localparam int NREGS = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        i_ready = 1'b0;
  logic        d_ready = 1'b0;
  logic [31:0] i_datain = 32'h0;
  logic [31:0] d_datain = 32'h0;
  logic        i_req, d_req, d_we, retire, halted, illegal;
  logic [31:0] i_addr, d_addr, d_dataout, pc;

  multicycle_cpu #(.NREGS(NREGS), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_datain(i_datain),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_dataout(d_dataout),
    .d_ready(d_ready), .d_datain(d_datain),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] mregs [32];
  logic [31:0] mpc;
  logic [31:0] last_pc, last_daddr, last_store;
  int          last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx);
    return (idx == 5'd0 || int'(idx) >= NREGS) ? 32'h0 : mregs[idx];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Drives one instruction through fetch/data handshakes and checks every cycle until retire.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic [31:0] ldat);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, simm, res, npc, ea;
    logic        wr, is_mem, is_st;
    int          base, mids, posts, lat, guard;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    a = mread(rs); b = mread(rt); simm = {{16{ins[15]}}, ins[15:0]};
    ea = a + simm; npc = mpc + 32'd4; res = 32'h0;
    wr = 1'b0; dst = rt; is_mem = 1'b0; is_st = 1'b0; base = 4;
    case (op)
      6'h00: begin
        wr = 1'b1; dst = rd;
        case (fn)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
      end
      6'h08: begin wr = 1'b1; res = a + simm; end
      6'h23: begin wr = 1'b1; is_mem = 1'b1; res = ldat; base = 5; end
      6'h2b: begin is_mem = 1'b1; is_st = 1'b1; end
      6'h04: begin base = 3; if (a == b) npc = mpc + 32'd4 + (simm << 2); end
      default: begin base = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
    endcase
    mids  = is_mem ? 2 : base - 1;
    posts = (op == 6'h23) ? 1 : 0;

    for (int k = 0; k <= iw; k++) begin
      chk("fetch_ctl", {28'h0, i_req, d_req, halted, illegal}, 32'h8);
      chk("fetch_addr", i_addr, mpc);
      if (k > 0) chk("fetch_noretire", 32'(retire), 32'h0);
      i_ready  = (k == iw);
      i_datain = (k == iw) ? ins : $urandom();
      @(negedge clock);
    end
    i_ready = 1'b0; i_datain = $urandom();
    lat = iw + 1;
    for (int m = 0; m < mids; m++) begin
      chk("mid_ctl", {27'h0, i_req, d_req, retire, halted, illegal}, 32'h0);
      @(negedge clock); lat++;
    end
    if (is_mem) begin
      for (int k = 0; k <= dw; k++) begin
        chk("mem_ctl", {28'h0, i_req, d_req, d_we, retire}, {28'h0, 1'b0, 1'b1, is_st, 1'b0});
        chk("mem_addr", d_addr, ea);
        if (is_st) chk("store_data", d_dataout, b);
        last_daddr = d_addr; last_store = d_dataout;
        d_ready  = (k == dw);
        d_datain = (k == dw) ? ldat : $urandom();
        @(negedge clock); lat++;
      end
      d_ready = 1'b0; d_datain = $urandom();
    end
    for (int m = 0; m < posts; m++) begin
      chk("wb_ctl", {27'h0, i_req, d_req, retire, halted, illegal}, 32'h0);
      @(negedge clock); lat++;
    end
    guard = 0;
    while (!retire && guard < 20) begin
      @(negedge clock); lat++; guard++;
    end
    chk("retire", 32'(retire), 32'h1);
    chk("latency", 32'(lat), 32'(base + iw + (is_mem ? dw : 0)));
    chk("retire_pc", pc, npc);
    last_pc = pc; last_lat = lat;
    if (wr && dst != 5'd0 && int'(dst) < NREGS) mregs[dst] = res;
    mpc = npc;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_ctl", {26'h0, i_req, d_req, d_we, retire, halted, illegal}, 32'h0);
    chk("reset_pc", pc, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mpc = 32'h0;
    for (int c = 0; c < 2; c++) begin
      chk("idle_hold", {30'h0, i_req, d_req}, 32'h0);
      @(negedge clock);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5];
    logic [4:0] rs, rt, rd;
    int sel;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    rs = 5'($urandom_range(0, 15)); rt = 5'($urandom_range(0, 15)); rd = 5'($urandom_range(0, 15));
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: return rtype(rs, rt, rd, fns[$urandom_range(0, 4)]);
      4, 5:       return itype(6'h08, rs, rt, 16'($urandom()));
      6:          return itype(6'h23, rs, rt, 16'($urandom()));
      7:          return itype(6'h2b, rs, rt, 16'($urandom()));
      8:          return itype(6'h04, rs, ($urandom_range(0, 1) != 0) ? rs : rt, 16'($urandom()));
      default:    return jtype(26'($urandom()));
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();
    do_start();

    run_instr(itype(6'h08, 5'd0, 5'd2, 16'h3c00), 0, 0, 32'h0);
    run_instr(itype(6'h23, 5'd0, 5'd1, 16'h0001), 0, 0, 32'h0000_00ab);
    chk("lw_daddr", last_daddr, 32'h1);
    chk("lw_latency", 32'(last_lat), 32'd5);
    run_instr(itype(6'h04, 5'd0, 5'd0, 16'hffff), 0, 0, 32'h0);
    chk("beq_self_pc", last_pc, 32'h8);
    chk("beq_latency", 32'(last_lat), 32'd3);
    run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h20), 3, 0, 32'h0);
    chk("ifetch_wait_latency", 32'(last_lat), 32'd7);
    run_instr(itype(6'h2b, 5'd0, 5'd3, 16'h0), 0, 0, 32'h0);
    chk("add_result", last_store, 32'h0000_3cab);
    run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h22), 0, 0, 32'h0);
    run_instr(itype(6'h2b, 5'd0, 5'd3, 16'h0), 0, 2, 32'h0);
    chk("sub_result", last_store, 32'hffff_c4ab);
    run_instr(rtype(5'd2, 5'd1, 5'd3, 6'h2a), 0, 0, 32'h0);
    run_instr(itype(6'h2b, 5'd0, 5'd3, 16'h0), 0, 0, 32'h0);
    chk("slt_result", last_store, 32'h0);
    run_instr(itype(6'h08, 5'd1, 5'd9, 16'h0005), 0, 0, 32'h0);
    run_instr(rtype(5'd1, 5'd1, 5'd0, 6'h20), 0, 0, 32'h0);
    run_instr(itype(6'h2b, 5'd0, 5'd0, 16'h0), 0, 0, 32'h0);
    chk("gr0_reads_zero", last_store, 32'h0);
    run_instr(itype(6'h2b, 5'd0, 5'd9, 16'h0), 0, 0, 32'h0);
    chk("gr9_reads_zero", last_store, 32'h0);
    run_instr(itype(6'h2b, 5'd0, 5'd1, 16'h0), 0, 0, 32'h0);
    chk("gr1_unchanged", last_store, 32'h0000_00ab);
    run_instr(jtype(26'h10), 0, 0, 32'h0);
    chk("jump_pc", last_pc, 32'h40);

    for (int n = 0; n < 250; n++) begin
      int iw, dw;
      iw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      dw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      run_instr(rand_instr(), iw, dw, $urandom());
    end

    // Unsupported opcode: core halts and ignores start from then on.
    chk("illegal_fetch_addr", i_addr, mpc);
    i_ready = 1'b1; i_datain = 32'hfc00_0000;
    @(negedge clock);
    i_ready = 1'b0;
    chk("illegal_decode_ctl", {28'h0, i_req, d_req, halted, illegal}, 32'h0);
    @(negedge clock);
    for (int c = 0; c < 16; c++) begin
      chk("halt_ctl", {27'h0, i_req, d_req, retire, halted, illegal}, 32'h3);
      start = (c == 3);
      @(negedge clock);
    end
    start = 1'b0;
    chk("halted_flag", 32'(halted), 32'h1);

    // Reset while a load is waiting on d_ready.
    do_reset();
    do_start();
    chk("pend_fetch_addr", i_addr, 32'h0);
    i_ready = 1'b1; i_datain = itype(6'h23, 5'd0, 5'd1, 16'h0004);
    @(negedge clock);
    i_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("pend_dreq", 32'(d_req), 32'h1);
    @(negedge clock);
    chk("pend_dreq_held", 32'(d_req), 32'h1);
    do_reset();
    do_start();
    run_instr(itype(6'h2b, 5'd0, 5'd1, 16'h0), 0, 0, 32'h0);
    chk("aborted_lw_no_write", last_store, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter NREGS, default 8, meaning number of general registers (power of 2, 2..32).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning fetch address after reset.
REQ-003 Ports, clock and reset first: clock  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset; start  in  1  run request, sampled in IDLE.
REQ-004 i_req  out  1  fetch request; i_addr  out  32  fetch byte address; i_ready  in  1  fetch accept; i_datain  in  32  instruction, valid when i_ready=1.
REQ-005 d_req  out  1  data request; d_we  out  1  1=store; d_addr  out  32  data byte address; d_dataout  out  32  store data; d_ready  in  1  data accept; d_datain  in  32  load data, valid when d_ready=1.
REQ-006 pc  out  32  current instruction address; retire  out  1  one-cycle pulse per completed instruction; halted  out  1  core in HALT; illegal  out  1  HALT entered on an unsupported encoding.

Function
REQ-007 FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-008 IDLE -> FETCH when start=1, else hold; all requests low.
REQ-009 FETCH: i_req=1, i_addr=pc, both held stable until i_ready=1; on that edge latch i_datain into IR, go to DECODE.
REQ-010 DECODE: read rs into reg_A and rt into reg_B; unsupported opcode/funct -> HALT with illegal=1.
REQ-011 Supported: R-type funct add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; addi 001000; beq 000100; j 000010.
REQ-012 EXEC: ALU result into reg_C; R-type/addi -> WB; lw/sw -> MEM; beq/j update pc, pulse retire, go to FETCH.
REQ-013 Arithmetic is modulo 2^32 with no overflow trap; slt is signed; addi/lw/sw/beq immediates are sign-extended.
REQ-014 MEM: d_req=1, d_addr=reg_C, d_we=1 and d_dataout=reg_B for sw; all held stable until d_ready=1; sw then pulses retire and goes to FETCH, lw latches d_datain into reg_C1 and goes to WB.
REQ-015 WB: write reg_C (ALU) or reg_C1 (lw) to rd (R-type) or rt (addi/lw); pulse retire; pc <= pc+4; go to FETCH.
REQ-016 Non-branch pc update is pc+4; beq taken target is pc+4+(simm<<2), not taken is pc+4; j target is {pc_plus4[31:28], IR[25:0], 2'b00}.
REQ-017 Register 0 reads 0; writes to it are discarded.
REQ-018 A register field >= NREGS reads 0 and discards writes.
REQ-019 Minimum latency from FETCH entry to retire, with ready=1 on first request cycle: beq/j 3, R-type/addi/sw 4, lw 5 cycles.
REQ-020 Each wait cycle with ready=0 adds exactly one cycle; requests are never withdrawn before ready.
REQ-021 HALT is absorbing until reset; start is ignored outside IDLE.

Reset
REQ-022 reset_n=0 immediately forces state IDLE, pc=RESET_PC, IR, reg_A, reg_B, reg_C, reg_C1 and all registers to 0, and i_req, d_req, d_we, retire, halted and illegal to 0.
REQ-023 Reset asserted mid-request abandons the transaction, and no register write from that instruction occurs.

Structure
REQ-024 Shared package cpu_pkg holds the opcode and funct constants, the FSM state enum and the ALU op enum.
REQ-025 One sub-module, cpu_alu: combinational add/sub/and/or/slt plus a zero flag.

Verification
REQ-026 lw gr1,1(gr0) with d_datain=32'h0000_00ab and ready=1 -> d_addr=1, gr1=32'h0000_00ab, retire 5 cycles after FETCH entry.
REQ-027 gr1=32'hab, gr2=32'h3c00, add gr3,gr1,gr2 -> gr3=32'h0000_3cab; sub gr3,gr1,gr2 -> 32'hffff_c4ab; slt gr3,gr2,gr1 -> 0.
REQ-028 i_ready held low 3 cycles -> i_addr stable throughout, and the retire pulse is delayed by exactly 3 cycles.
REQ-029 beq gr0,gr0,-1 at pc=8 -> pc=8 after retire; j 26'h10 -> pc=32'h40.
REQ-030 Opcode 111111 -> halted=1, illegal=1 after DECODE, no further i_req; reset_n=0 during a pending d_req -> d_req=0 immediately, pc=RESET_PC.
REQ-031 With NREGS=8, addi to rt=9 -> no register changes; add gr0,gr1,gr1 -> gr0 still reads 0.
